// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
// Raises div_stall while it runs and presents HI (remainder) / LO (quotient) for one ready cycle.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             div_stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] rem_step, quo_step;

    // Magnitudes; the most negative value maps onto itself, which reads correctly as unsigned.
    assign a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
    assign b_abs = (signed_div && b[WIDTH-1]) ? -b : b;

    // One restoring step; the extra bit keeps the subtract borrow-exact.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        if (diff[WIDTH]) begin
            rem_step = rem_sh[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            rem_d   = '0;
                            quo_d   = a_abs;
                            dvs_d   = b_abs;
                            qsign_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rsign_d = signed_div & a[WIDTH-1];
                            cnt_d   = '0;
                            state_d = BUSY;
                        end else begin
                            hi_d    = a;
                            lo_d    = '1;
                            state_d = DONE;
                        end
                    end
                end
                BUSY: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_d    = rsign_q ? -rem_step : rem_step;
                        lo_d    = qsign_q ? -quo_step : quo_step;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: the datapath is always loaded before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        qsign_q <= qsign_d;
        rsign_q <= rsign_d;
    end

    assign ready     = (state_q == DONE);
    assign div_stall = resetn & ~flush & (((state_q == IDLE) & start) | (state_q == BUSY));
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, signed/unsigned results, divide-by-zero,
// flush abort, mid-divide reset and back-to-back divides.
module tb_div_seq;
    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        div_stall;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .div_stall  (div_stall),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts a divide at the next cycle and holds start until ready; operands are
    // scrambled after cycle 0 so only the latched copies can give the right answer.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_lat);
        int          stall_n;
        int          rdy_at;
        logic [31:0] got_lo;
        logic [31:0] got_hi;
        stall_n = 0;
        rdy_at  = -1;
        got_lo  = '0;
        got_hi  = '0;
        for (int k = 0; k < 100 && rdy_at < 0; k++) begin
            @(negedge clk);
            start      = 1'b1;
            flush      = 1'b0;
            signed_div = (k == 0) ? sgn : ~sgn;
            a          = (k == 0) ? av : ~av;
            b          = (k == 0) ? bv : (bv ^ 32'h5);
            #1;
            if (div_stall) stall_n++;
            if (ready) begin
                rdy_at = k;
                got_lo = lo;
                got_hi = hi;
            end
        end
        check({tag, "_ready_cycle"}, rdy_at, exp_lat);
        check({tag, "_stall_cycles"}, stall_n, exp_lat);
        check({tag, "_lo"}, got_lo, exp_lo);
        check({tag, "_hi"}, got_hi, exp_hi);
    endtask

    // One cycle with start dropped: DUT must be idle with the last result held.
    task automatic idle_check(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        a     = 32'h1234_5678;
        b     = 32'h9;
        #1;
        check({tag, "_idle_ready"}, ready, 0);
        check({tag, "_idle_stall"}, div_stall, 0);
        check({tag, "_idle_lo"}, lo, exp_lo);
        check({tag, "_idle_hi"}, hi, exp_hi);
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        flush      = 1'b0;

        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_ready", ready, 0);
        check("reset_stall", div_stall, 0);
        check("reset_lo", lo, 0);
        check("reset_hi", hi, 0);
        resetn = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        idle_check("divu_100_7", 32'd14, 32'd2);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        idle_check("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 33);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 33);
        run_div("divu_min_3", 1'b0, 32'h8000_0000, 32'h3, 32'h2AAA_AAAA, 32'h2, 33);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        idle_check("divu_5_0", 32'hFFFF_FFFF, 32'd5);
        run_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
        idle_check("div_m7_0", 32'hFFFF_FFFF, 32'hFFFF_FFF9);

        // Flush at cycle 10 of a divide: abort without touching hi/lo.
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            start      = 1'b1;
            signed_div = 1'b0;
            a          = 32'd100;
            b          = 32'd7;
            flush      = (k == 10);
            #1;
            if (k == 9)  check("flush_pre_stall", div_stall, 1);
            if (k == 10) check("flush_stall", div_stall, 0);
        end
        idle_check("flush_abort", 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run_div("after_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        idle_check("after_flush", 32'd14, 32'd2);

        // Flush together with start in IDLE: the divide is not accepted.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        a     = 32'd20;
        b     = 32'd3;
        #1;
        check("flush_idle_stall", div_stall, 0);
        idle_check("flush_idle", 32'd14, 32'd2);

        // Reset at cycle 15 of a divide.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            start      = 1'b1;
            signed_div = 1'b0;
            a          = 32'd100;
            b          = 32'd7;
        end
        @(negedge clk);
        resetn = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("midreset_ready", ready, 0);
        check("midreset_stall", div_stall, 0);
        check("midreset_lo", lo, 0);
        check("midreset_hi", hi, 0);

        // Back-to-back: second start in the IDLE cycle right after DONE.
        run_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
        run_div("b2b_10_4", 1'b0, 32'd10, 32'd4, 32'd2, 32'd2, 33);
        idle_check("b2b_10_4", 32'd2, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
